// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped cache, its refill controller and benches.
package cache_pkg;

   // Default geometry; index/tag split is half the address each way.
   localparam int DEF_ADDR_WIDTH = 8;
   localparam int INDEX_WIDTH    = DEF_ADDR_WIDTH / 2;
   localparam int TAG_WIDTH      = DEF_ADDR_WIDTH - DEF_ADDR_WIDTH / 2;

   // Refill controller states.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOOKUP = 3'd1,
      ST_CHECK  = 3'd2,
      ST_MEM_RD = 3'd3,
      ST_FILL   = 3'd4,
      ST_WR     = 3'd5,
      ST_MEM_WR = 3'd6
   } state_t;

   // Geometry helpers for non-default address widths.
   function automatic int index_width(input int aw);
      return aw / 2;
   endfunction

   function automatic int tag_width(input int aw);
      return aw - aw / 2;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   // Count increments, holding at the maximum value.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/cache_refill_controller.sv
// CPU-side controller for the direct-mapped cache: lookup, read-miss refill
// from main memory, write-through/write-allocate stores, hit/miss counters.
module cache_refill_controller
   import cache_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int CACHE_SIZE = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic                  cpu_ready,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_busy,
   output logic [ADDR_WIDTH-1:0] cache_addr,
   output logic [DATA_WIDTH-1:0] cache_wr_data,
   output logic                  cache_mem_read,
   output logic                  cache_mem_write,
   input  logic [DATA_WIDTH-1:0] cache_read_data,
   input  logic                  cache_hit,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [CNT_WIDTH-1:0]  hit_count,
   output logic [CNT_WIDTH-1:0]  miss_count
);

   if (CACHE_SIZE != (1 << (ADDR_WIDTH / 2))) begin : g_size_check
      $error("CACHE_SIZE must equal 2**(ADDR_WIDTH/2)");
   end

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  hit_inc;
   logic                  miss_inc;

   // Store/load choice is folded into the first state, so cpu_we needs no latch.
   // Sequencer: accept, lookup, refill or write-through, registered completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         cpu_ready <= 1'b0;
         cpu_rdata <= '0;
      end else begin
         cpu_ready <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (cpu_req) begin
                  addr_q  <= cpu_addr;
                  wdata_q <= cpu_wdata;
                  state   <= cpu_we ? ST_WR : ST_LOOKUP;
               end
            end
            ST_LOOKUP: state <= ST_CHECK;
            ST_CHECK: begin
               if (cache_hit) begin
                  cpu_rdata <= cache_read_data;
                  cpu_ready <= 1'b1;
                  state     <= ST_IDLE;
               end else begin
                  state <= ST_MEM_RD;
               end
            end
            ST_MEM_RD: begin
               if (mem_ack) begin
                  rdata_q <= mem_rdata;
                  state   <= ST_FILL;
               end
            end
            ST_FILL: begin
               cpu_rdata <= rdata_q;
               cpu_ready <= 1'b1;
               state     <= ST_IDLE;
            end
            ST_WR: state <= ST_MEM_WR;
            ST_MEM_WR: begin
               if (mem_ack) begin
                  cpu_ready <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Cache and memory strobes decoded from state and latches only.
   always_comb begin
      cache_addr      = addr_q;
      cache_wr_data   = (state == ST_FILL) ? rdata_q : wdata_q;
      cache_mem_read  = (state == ST_LOOKUP);
      cache_mem_write = (state == ST_FILL) || (state == ST_WR);
      mem_req         = (state == ST_MEM_RD) || (state == ST_MEM_WR);
      mem_we          = (state == ST_MEM_WR);
      mem_addr        = addr_q;
      mem_wdata       = wdata_q;
      cpu_busy        = (state != ST_IDLE);
   end

   // Lookup outcome strobes for the statistics counters.
   always_comb begin
      hit_inc  = (state == ST_CHECK) && cache_hit;
      miss_inc = (state == ST_CHECK) && !cache_hit;
   end

   sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (hit_inc),
      .count (hit_count)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (miss_inc),
      .count (miss_count)
   );

endmodule

// File: doc/cache_refill_controller.md
Name: cache_refill_controller

Overview:
- Requester-side controller that drives the team's direct-mapped cache (`addr`/`wr_data`/`mem_read`/`mem_write` in; `read_data`/`hit` out, registered, 1-cycle latency).
- Accepts CPU load/store requests and looks them up in the cache. On a read miss it fetches the word from main memory over a req/ack handshake and refills the line.
- Policy: write-through, write-allocate.
- Exports saturating hit/miss counters.

Parameters:
- DATA_WIDTH, 32, data word width; must match the cache.
- ADDR_WIDTH, 8, address width; must match the cache.
- CACHE_SIZE, 16, cache entries; must equal 2**(ADDR_WIDTH/2).
- CNT_WIDTH, 16, width of the hit and miss counters.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  request valid; sampled only in IDLE.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_WIDTH  request address.
- cpu_wdata  in  DATA_WIDTH  store data.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_WIDTH  load data; valid while cpu_ready=1, held until the next load completes.
- cpu_busy  out  1  high when state != IDLE.
- cache_addr  out  ADDR_WIDTH  to cache addr.
- cache_wr_data  out  DATA_WIDTH  to cache wr_data.
- cache_mem_read  out  1  to cache mem_read.
- cache_mem_write  out  1  to cache mem_write.
- cache_read_data  in  DATA_WIDTH  from cache read_data.
- cache_hit  in  1  from cache hit.
- mem_req  out  1  main-memory request; held until acknowledged.
- mem_we  out  1  main-memory write enable.
- mem_addr  out  ADDR_WIDTH  main-memory address.
- mem_wdata  out  DATA_WIDTH  main-memory write data.
- mem_ack  in  1  one-cycle completion from memory.
- mem_rdata  in  DATA_WIDTH  read data; valid when mem_ack=1.
- hit_count  out  CNT_WIDTH  read hits, saturating.
- miss_count  out  CNT_WIDTH  read misses, saturating.

Behaviour:
- **Reset.** rst high at a rising edge forces:
  - state = IDLE;
  - all outputs, including cpu_rdata and both counters, to 0;
  - the addr/data latches to 0.
  - rst takes priority over every other event.
  - Reset mid-transaction abandons the transaction: mem_req is low from the following cycle and no cpu_ready is issued.
  - The controller does not clear cache valid bits; the cache's own rst does that.
- **Accept.** In IDLE with cpu_req=1, latch cpu_addr, cpu_we and cpu_wdata at the edge. The CPU need not hold its inputs after that edge.
- **States:** IDLE, LOOKUP, CHECK, MEM_RD, FILL, WR, MEM_WR.
- **LOOKUP.** cache_mem_read=1, cache_addr=latched address. Go to CHECK.
- **CHECK.** Sample cache_hit and cache_read_data, which the cache registered at the previous edge.
  - Hit: cpu_rdata <= cache_read_data; cpu_ready <= 1; hit_count++; go to IDLE.
  - Miss: miss_count++; go to MEM_RD.
- **MEM_RD.** mem_req=1, mem_we=0, mem_addr=latched address, all held stable until the edge where mem_ack=1. At that edge, capture mem_rdata and go to FILL.
- **FILL.** cache_mem_write=1 with cache_wr_data=captured data. cpu_rdata <= captured data; cpu_ready <= 1; go to IDLE.
- **WR.** cache_mem_write=1 with cache_wr_data=latched wdata (allocates/updates the line). Go to MEM_WR.
- **MEM_WR.** mem_req=1, mem_we=1, mem_wdata=latched wdata, held until mem_ack=1. Then cpu_ready <= 1 and go to IDLE.
- **Latency:**
  - Read hit: cpu_ready high in the cycle after the 2nd edge following the accept edge.
  - Read miss: 3 edges + memory wait + 1 edge.
  - Write: 2 edges + memory wait.
- **Back-to-back.** A new cpu_req may be accepted in the cycle cpu_ready is high, since the state is already IDLE. The FILL/WR cache write commits at the edge leaving that state, so the next LOOKUP sees the updated line.
- **Ignored inputs:**
  - mem_ack outside MEM_RD/MEM_WR.
  - cpu_req outside IDLE.
  - cache_hit/cache_read_data outside CHECK.
- **Strobes.** cache_mem_read and cache_mem_write are never high in the same cycle. Both are 0 in IDLE, CHECK, MEM_RD and MEM_WR.
- **Counters.** Saturate at 2**CNT_WIDTH-1 and never wrap. Stores are not counted.
- **Output timing.** cpu_ready and cpu_rdata are registered. mem_*, cache_* and cpu_busy are decoded from state and latches only, with no combinational path from any input.

Decomposition:
- **Shared package/header `cache_pkg`:**
  - state encodings (3-bit localparams);
  - INDEX_WIDTH = ADDR_WIDTH/2, TAG_WIDTH = ADDR_WIDTH - ADDR_WIDTH/2, for reuse by the cache and the bench.
- **Sub-module `sat_counter`** (params WIDTH; ports clk, rst, inc, count), instantiated twice for hit_count and miss_count.

Test Plan:
1. Read miss after rst, addr=0x35, memory returns 0xDEADBEEF with mem_ack 3 cycles after mem_req rises:
   - mem_req high with mem_addr=0x35 until ack;
   - cpu_ready pulses once with cpu_rdata=0xDEADBEEF;
   - miss_count=1, hit_count=0.
2. Read 0x35 again → cpu_ready 2 edges after accept with 0xDEADBEEF; mem_req stays 0; hit_count=1.
3. Store 0x47 data 0x12345678, ack after 1 cycle, then load 0x47:
   - one cache write cycle, then mem_req/mem_we=1 with mem_wdata=0x12345678;
   - the load hits with 0x12345678.
4. Conflict: load 0x15 after 0x35 is cached (same index 5, different tag) → miss and refill. A following load of 0x35 misses again.
5. rst asserted during MEM_RD before mem_ack:
   - next cycle mem_req=0, cpu_busy=0, counters=0, no cpu_ready;
   - a late mem_ack is ignored.
6. CNT_WIDTH=2, 5 consecutive hits on 0x35 → hit_count sticks at 3.
